// File: rtl/game_pkg.sv
// Shared game constants, key codes and state types for the tank game.
// Dimensions are shared with the colour mapper and tank position logic.
package game_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int TANK_W         = 70;
  localparam int TANK_H         = 50;
  localparam int BULLET_VX      = 4;
  localparam int GRAVITY        = 1;
  localparam int VY_MAX         = 15;
  localparam int START_HP       = 3;
  localparam int RESOLVE_FRAMES = 30;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;

  localparam logic [3:0] POWER_INIT = 4'd8;
  localparam logic [3:0] POWER_MAX  = 4'd15;
  localparam logic [3:0] POWER_MIN  = 4'd1;
  localparam logic [1:0] HP_INIT    = 2'(START_HP);
  localparam logic [4:0] RES_LAST   = 5'(RESOLVE_FRAMES - 1);

  typedef enum logic [1:0] {
    SELECT = 2'b00,
    FIGHT  = 2'b01,
    OVER   = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    AIM     = 2'b00,
    FLY     = 2'b01,
    RESOLVE = 2'b10
  } fight_phase_t;

endpackage

// File: rtl/bullet_kinematics.sv
// Bullet position/velocity with gravity, plus hit and miss tests
// evaluated on the position the next step would produce.
module bullet_kinematics
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       launch,
  input  logic       step,
  input  logic       dirLeft,
  input  logic [3:0] launchPower,
  input  logic [9:0] startX,
  input  logic [9:0] startY,
  input  logic [9:0] targetX,
  input  logic [9:0] targetY,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic       hit,
  output logic       miss
);
  localparam logic signed [10:0] HALF_W = 11'(TANK_W / 2);
  localparam logic signed [10:0] VX     = 11'(BULLET_VX);
  localparam logic signed [10:0] GRAV   = 11'(GRAVITY);
  localparam logic signed [10:0] VYCAP  = 11'(VY_MAX);
  localparam logic signed [10:0] SW     = 11'(SCREEN_W);
  localparam logic signed [10:0] SH     = 11'(SCREEN_H);
  localparam logic signed [11:0] TW     = 12'(TANK_W);
  localparam logic signed [11:0] TH     = 12'(TANK_H);
  localparam logic signed [10:0] XLIM   = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] YLIM   = 11'(SCREEN_H - 1);
  localparam logic [9:0]         XTOP   = 10'(SCREEN_W - 1);
  localparam logic [9:0]         YTOP   = 10'(SCREEN_H - 1);

  logic signed [10:0] x, y, vx, vy;
  logic signed [10:0] nx, ny, vyInc, nvy;
  logic signed [11:0] dx, dy;

  assign nx    = x + vx;
  assign ny    = y + vy;
  assign vyInc = vy + GRAV;
  assign nvy   = (vyInc > VYCAP) ? VYCAP : vyInc;

  // 12-bit differences keep the box test exact over the full range
  assign dx = {nx[10], nx} - {2'b00, targetX};
  assign dy = {ny[10], ny} - {2'b00, targetY};

  assign hit  = !dx[11] && (dx < TW) && !dy[11] && (dy < TH);
  assign miss = nx[10] || (nx >= SW) || (ny >= SH);

  assign posX = x[10] ? 10'd0 : ((x > XLIM) ? XTOP : x[9:0]);
  assign posY = y[10] ? 10'd0 : ((y > YLIM) ? YTOP : y[9:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      x  <= '0;
      y  <= '0;
      vx <= '0;
      vy <= '0;
    end else if (launch) begin
      x  <= $signed({1'b0, startX}) + HALF_W;
      y  <= $signed({1'b0, startY});
      vx <= dirLeft ? -VX : VX;
      vy <= -$signed({7'd0, launchPower});
    end else if (step) begin
      x  <= nx;
      y  <= ny;
      vy <= nvy;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Game-flow controller: turns, aiming, bullet flight and hit points.
// Game logic advances on frame ticks; menu keys act every clock.
module turn_sequencer
  import game_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] Tank0X,
  input  logic [9:0] Tank0Y,
  input  logic [9:0] Tank1X,
  input  logic [9:0] Tank1Y,
  output logic [1:0] currentState,
  output logic [1:0] currentTank,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       bullet_active,
  output logic       transparent,
  output logic [1:0] hp0,
  output logic [1:0] hp1,
  output logic [3:0] power
);
  game_state_t  state;
  fight_phase_t phase;

  logic       frameQ, tick;
  logic       shooter, arm, hitShot;
  logic [4:0] frameCnt;
  logic       inAim, inFly, inRes;
  logic       launch, step, hit, miss;
  logic [1:0] targetHp;
  logic [9:0] shotX, shotY, tgtX, tgtY;

  assign tick  = frame_clk & ~frameQ;
  assign inAim = (state == FIGHT) && (phase == AIM);
  assign inFly = (state == FIGHT) && (phase == FLY);
  assign inRes = (state == FIGHT) && (phase == RESOLVE);

  // arm blocks a space key that was already held when the turn began
  assign launch = tick && inAim && arm
               && (keycode == KEY_SPACE);
  assign step   = tick && inFly;

  assign shotX    = shooter ? Tank1X : Tank0X;
  assign shotY    = shooter ? Tank1Y : Tank0Y;
  assign tgtX     = shooter ? Tank0X : Tank1X;
  assign tgtY     = shooter ? Tank0Y : Tank1Y;
  assign targetHp = shooter ? hp0 : hp1;

  bullet_kinematics u_bullet (
    .clk         (Clk),
    .reset       (Reset),
    .launch      (launch),
    .step        (step),
    .dirLeft     (shooter),
    .launchPower (power),
    .startX      (shotX),
    .startY      (shotY),
    .targetX     (tgtX),
    .targetY     (tgtY),
    .posX        (BulletX),
    .posY        (BulletY),
    .hit         (hit),
    .miss        (miss)
  );

  assign currentState  = state;
  assign currentTank   = {1'b0, shooter};
  assign bullet_active = inFly;
  assign transparent   = inRes && hitShot && frameCnt[2];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frameQ   <= 1'b0;
      state    <= SELECT;
      phase    <= AIM;
      shooter  <= 1'b0;
      arm      <= 1'b0;
      hitShot  <= 1'b0;
      frameCnt <= '0;
      hp0      <= HP_INIT;
      hp1      <= HP_INIT;
      power    <= POWER_INIT;
    end else begin
      frameQ <= frame_clk;
      unique case (state)
        SELECT: begin
          if (keycode == KEY_ENTER) begin
            state   <= FIGHT;
            phase   <= AIM;
            shooter <= 1'b0;
            hp0     <= HP_INIT;
            hp1     <= HP_INIT;
            power   <= POWER_INIT;
            arm     <= 1'b0;
          end
        end
        FIGHT: begin
          if (tick) begin
            unique case (phase)
              AIM: begin
                if (keycode != KEY_SPACE) arm <= 1'b1;
                if (launch) begin
                  phase <= FLY;
                end else if (keycode == KEY_W) begin
                  if (power != POWER_MAX) power <= power + 4'd1;
                end else if (keycode == KEY_S) begin
                  if (power != POWER_MIN) power <= power - 4'd1;
                end
              end
              FLY: begin
                if (hit) begin
                  if (shooter) hp0 <= targetHp - 2'd1;
                  else         hp1 <= targetHp - 2'd1;
                  if (targetHp == 2'd1) begin
                    state <= OVER;
                    phase <= AIM;
                  end else begin
                    phase    <= RESOLVE;
                    hitShot  <= 1'b1;
                    frameCnt <= '0;
                  end
                end else if (miss) begin
                  phase    <= RESOLVE;
                  hitShot  <= 1'b0;
                  frameCnt <= '0;
                end
              end
              RESOLVE: begin
                if (frameCnt == RES_LAST) begin
                  shooter  <= ~shooter;
                  arm      <= 1'b0;
                  power    <= POWER_INIT;
                  hitShot  <= 1'b0;
                  frameCnt <= '0;
                  phase    <= AIM;
                end else begin
                  frameCnt <= frameCnt + 5'd1;
                end
              end
              default: phase <= AIM;
            endcase
          end
        end
        OVER: begin
          if (keycode == KEY_ENTER) begin
            state <= SELECT;
            hp0   <= HP_INIT;
            hp1   <= HP_INIT;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller that sequences the tank/bullet rendering datapath.
- Owns the top-level game state, whose turn it is, bullet launch and flight, hit resolution and hit points.
- Drives the colour mapper's currentState, currentTank, BulletX/BulletY and transparent inputs.
- Advances once per video frame; keyboard keycode is its only user input.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- TANK_W, 70, tank sprite width
- TANK_H, 50, tank sprite height
- BULLET_VX, 4, horizontal bullet speed, pixels/frame
- GRAVITY, 1, added to vertical velocity each frame
- VY_MAX, 15, positive (downward) vertical velocity clamp
- START_HP, 3, hit points per tank at game start
- RESOLVE_FRAMES, 30, pause after a shot before the turn passes

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  vsync-rate level signal, sampled in the Clk domain
- keycode  in  8  current USB keycode, 0x00 = none
- Tank0X, Tank0Y  in  10 each  top-left of tank 0
- Tank1X, Tank1Y  in  10 each  top-left of tank 1
- currentState  out  2  00 SELECT, 01 FIGHT, 10 OVER
- currentTank  out  2  active shooter, 0 or 1
- BulletX, BulletY  out  10 each  bullet centre
- bullet_active  out  1  bullet in flight
- transparent  out  1  blink enable for the hit tank
- hp0, hp1  out  2 each  remaining hit points
- power  out  4  current launch power, 1..15

Behaviour:
Frame tick
- frame_clk is registered once; tick = current AND NOT previous (rising edge).
- All game updates occur only on tick cycles, except SELECT/OVER key handling, which is evaluated every Clk.

Reset
- Reset is synchronous and dominates everything, including mid-flight.
- Reset values: currentState=00, currentTank=0, BulletX=0, BulletY=0, bullet_active=0, transparent=0, hp0=hp1=START_HP, power=8.
- All internal phase and counter registers clear.

SELECT
- keycode 0x28 (Enter): go to FIGHT/AIM, currentTank=0, both hp=START_HP, power=8, launch arm cleared.

FIGHT/AIM
- On tick: W (0x1A) increments power, saturating at 15; S (0x16) decrements power, saturating at 1.
- Space (0x2C) on tick with arm=1 launches:
  - BulletX = shooter X + TANK_W/2; BulletY = shooter Y.
  - vx = +BULLET_VX for tank 0, −BULLET_VX for tank 1; vy = −power.
  - bullet_active=1; go to FLY.
- arm sets whenever keycode ≠ 0x2C, so a held space key fires only once per turn.

FIGHT/FLY
- On each tick, in 11-bit signed arithmetic: X += vx, Y += vy, then vy = min(vy + GRAVITY, VY_MAX).
- Hit test on the updated position: 0 ≤ X − targetX < TANK_W and 0 ≤ Y − targetY < TANK_H, where target is the non-shooter.
- Miss test: X < 0, X ≥ SCREEN_W, or Y ≥ SCREEN_H. Y < 0 is not a miss; the bullet keeps flying.
- Hit and miss on the same tick: hit wins.
- Hit: decrement target hp.
  - New hp = 0 → OVER, bullet_active=0.
  - Otherwise → RESOLVE with transparent blinking.
- Miss: → RESOLVE without blink. bullet_active=0 on both exits.
- Outputs clamp to 0..SCREEN_W−1 / 0..SCREEN_H−1; negative Y outputs 0.

FIGHT/RESOLVE
- Frame counter counts RESOLVE_FRAMES ticks.
- transparent = counter[2] when the shot hit, else 0.
- On expiry: currentTank toggles, arm=0, power=8, transparent=0, → AIM.

OVER
- currentState=10; Enter → SELECT. hp values are held until then.

Latency
- Registered outputs update the cycle after the tick is detected.

Decomposition:
- Shared package game_pkg: game_state_t enum (SELECT, FIGHT, OVER), fight_phase_t enum (AIM, FLY, RESOLVE), keycode constants (KEY_ENTER, KEY_SPACE, KEY_W, KEY_S), and screen/tank dimension localparams shared with the colour mapper and tank position modules.
- Natural sub-module: bullet_kinematics. It holds position/velocity registers, applies the gravity update, and performs the hit/miss tests. The sequencer FSM instantiates it and drives launch/clear strobes.

Test Plan:
- Reset held mid-FLY (tank 1 shooting) → next cycle: currentState=00, bullet_active=0, hp0=hp1=3, currentTank=0.
- SELECT, Enter, 3 ticks of W → power=11; space on tick with Tank0=(100,300) → BulletX=135, BulletY=300, bullet_active=1; after one tick BulletX=139, BulletY=289.
- Space held across a full turn → exactly one launch per turn; no launch until a tick with keycode≠0x2C occurs.
- Tank 0 shot with power=15 toward Tank1=(600,300) leaves the right edge → miss, transparent stays 0, and after 30 ticks currentTank=1, power=8.
- Bullet placed to enter Tank1's box on the same tick that Y ≥ 480 → hit wins, hp1 3→2, transparent toggles every 4 ticks during RESOLVE.
- Third hit on tank 1 → currentState=10, hp1=0, bullet_active=0; Enter → currentState=00.
